i2f64_ctrl: RTL and testbench

Sequencing and result-buffering stage around the single-cycle-latency integer-to-double converter. It sits on the FPU issue side.
- Accepts tagged conversion requests over a valid/ready handshake.
- Drives the converter's ce/op/rm/i inputs and captures the converter's o output.
- Computes IEEE flags and queues tagged results in an in-order FIFO for writeback.
- Guarantees no result is lost, using credit-based admission.

---
 rtl/i2f64_ctrl_pkg.sv | 54 +++++
 rtl/i2f64_ctrl_if.sv | 55 +++++
 rtl/i2f64_ctrl_fifo.sv | 66 ++++++
 rtl/i2f64_ctrl.sv | 104 ++++++++++
 tb/tb_i2f64_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2f64_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fp64Pkg : shared double-precision definitions used by the integer-to-double
// sequencing stage.
//   FPWID / MSB / EMSB / FMSB : operand width and field boundaries of an
//                               IEEE-754 binary64 value
//   CVT_LAT_DEFAULT           : latency of the converter in ce-enabled cycles
//   i2f_flags_t               : {nx, zf, nf} result flags
//   calc_flags()              : flags of a conversion, from the raw operand
// ---------------------------------------------------------------------------
package fp64Pkg;

  localparam int FPWID = 64;
  localparam int MSB   = FPWID - 1;
  localparam int EMSB  = 62;
  localparam int FMSB  = 51;

  localparam int CVT_LAT_DEFAULT = 1;

  // bits that a binary64 significand holds, hidden bit included
  localparam int MANT_BITS = FMSB + 2;
  localparam int IDXW      = $clog2(FPWID) + 1;

  typedef struct packed {
    logic nx;
    logic zf;
    logic nf;
  } i2f_flags_t;

  // Inexact iff the set bits of the magnitude span more than the significand
  // can hold; this does not depend on the rounding mode.
  function automatic i2f_flags_t calc_flags(input logic [FPWID-1:0] v,
                                            input logic op);
    i2f_flags_t       f;
    logic [FPWID-1:0] mag;
    logic [IDXW-1:0]  hi;
    logic [IDXW-1:0]  lo;
    f.nf = op & v[MSB];
    f.zf = (v == {FPWID{1'b0}});
    // two's complement of the signed minimum is itself, which is the
    // correct unsigned magnitude 2^63
    mag  = f.nf ? ({FPWID{1'b0}} - v) : v;
    hi   = {IDXW{1'b0}};
    lo   = {IDXW{1'b0}};
    for (int i = 0; i < FPWID; i++) begin
      if (mag[i]) hi = IDXW'(i);
    end
    for (int i = FPWID - 1; i >= 0; i--) begin
      if (mag[i]) lo = IDXW'(i);
    end
    f.nx = ((hi - lo) >= IDXW'(MANT_BITS));
    return f;
  endfunction

endpackage

// File: rtl/i2f64_ctrl_if.sv
// ---------------------------------------------------------------------------
// i2f64_ctrl_if : request, converter and result signals of the
// integer-to-double sequencing stage.
//   req_*  : tagged conversion request (valid/ready)
//   cvt_*  : converter ce/op/rm/i outputs and converter result cvt_o
//   res_*  : in-order result queue head (valid/ready), flags and occupancy
// Modports:
//   slave  : the i2f64_ctrl block
//   master : issue side plus the converter itself
// ---------------------------------------------------------------------------
interface i2f64_ctrl_if #(
  parameter int FPWID = fp64Pkg::FPWID,
  parameter int TAGW  = 6,
  parameter int DEPTH = 4
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_op;
  logic [2:0]               req_rm;
  logic [FPWID-1:0]         req_int;
  logic [TAGW-1:0]          req_tag;

  logic                     cvt_ce;
  logic                     cvt_op;
  logic [2:0]               cvt_rm;
  logic [FPWID-1:0]         cvt_i;
  logic [FPWID-1:0]         cvt_o;

  logic                     res_valid;
  logic                     res_ready;
  logic [FPWID-1:0]         res_data;
  logic [TAGW-1:0]          res_tag;
  logic [2:0]               res_flags;
  logic [$clog2(DEPTH):0]   res_count;

  modport slave (
    input  req_valid, req_op, req_rm, req_int, req_tag,
    output req_ready,
    output cvt_ce, cvt_op, cvt_rm, cvt_i,
    input  cvt_o,
    output res_valid, res_data, res_tag, res_flags, res_count,
    input  res_ready
  );

  modport master (
    output req_valid, req_op, req_rm, req_int, req_tag,
    input  req_ready,
    input  cvt_ce, cvt_op, cvt_rm, cvt_i,
    output cvt_o,
    input  res_valid, res_data, res_tag, res_flags, res_count,
    output res_ready
  );

endinterface

// File: rtl/i2f64_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// fcvt_res_fifo : circular DEPTH x WIDTH result queue with explicit count.
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   i_push    : write i_data at the tail
//   i_pop     : drop the head (ignored when empty)
//   o_data    : current head entry (undefined content when empty)
//   o_count   : occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module fcvt_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 73
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop & (r_count != {(AW+1){1'b0}});
  assign w_push = i_push & ((r_count != C_FULL) | w_pop);

  // Storage array; entries are only observed through the count so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/i2f64_ctrl.sv
// ---------------------------------------------------------------------------
// i2f64_ctrl : sequencing and result buffering around the integer-to-double
// converter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : i2f64_ctrl_if.slave
//     req_*  in : tagged request; req_ready depends only on registered state
//     cvt_*  out: converter controls, copies of the request operand; cvt_o in
//     res_*  out: head of the in-order result queue, flags {nx,zf,nf}, count
// A request accepted at the edge ending cycle T has its converter result in
// cycle T+CVT_LAT; it is queued at the end of that cycle. Admission is
// credit-based (queued + in-flight < DEPTH) so a result is never dropped.
// ---------------------------------------------------------------------------
module i2f64_ctrl
  import fp64Pkg::*;
#(
  parameter int TAGW    = 6,
  parameter int DEPTH   = 4,
  parameter int CVT_LAT = CVT_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  i2f64_ctrl_if.slave bus
);

  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int ENTW = FPWID + TAGW + 3;
  localparam int CRW  = $clog2(DEPTH + CVT_LAT + 1) + 1;

  logic [CVT_LAT-1:0] r_pv;
  logic [TAGW-1:0]    r_ptag   [CVT_LAT];
  i2f_flags_t         r_pflags [CVT_LAT];

  logic               w_accept;
  i2f_flags_t         w_req_flags;
  logic               w_push;
  logic               w_pop;
  logic [ENTW-1:0]    w_push_data;
  logic [ENTW-1:0]    w_head;
  logic [CNTW-1:0]    w_count;
  logic [CRW-1:0]     w_credit;

  // converter runs freely except during reset; it samples the live operand
  assign bus.cvt_ce = ~rst;
  assign bus.cvt_op = bus.req_op;
  assign bus.cvt_rm = bus.req_rm;
  assign bus.cvt_i  = bus.req_int;

  assign w_req_flags = calc_flags(bus.req_int, bus.req_op);
  assign w_accept    = bus.req_valid & bus.req_ready;

  // Credits: queued entries plus results still inside the converter.
  always_comb begin
    w_credit = CRW'(w_count);
    for (int s = 0; s < CVT_LAT; s++) begin
      w_credit = w_credit + CRW'(r_pv[s]);
    end
  end

  assign bus.req_ready = (w_credit < CRW'(DEPTH));

  // Tracking pipeline mirrors the converter latency: {valid, tag, flags}.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= {CVT_LAT{1'b0}};
      for (int s = 0; s < CVT_LAT; s++) begin
        r_ptag[s]   <= {TAGW{1'b0}};
        r_pflags[s] <= '0;
      end
    end else begin
      r_pv[0]     <= w_accept;
      r_ptag[0]   <= bus.req_tag;
      r_pflags[0] <= w_req_flags;
      for (int s = 1; s < CVT_LAT; s++) begin
        r_pv[s]     <= r_pv[s-1];
        r_ptag[s]   <= r_ptag[s-1];
        r_pflags[s] <= r_pflags[s-1];
      end
    end
  end

  assign w_push      = r_pv[CVT_LAT-1];
  assign w_push_data = {bus.cvt_o, r_ptag[CVT_LAT-1], r_pflags[CVT_LAT-1]};
  assign w_pop       = bus.res_valid & bus.res_ready;

  fcvt_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // head is zeroed when empty so an idle queue shows all-zero outputs
  assign bus.res_valid = (w_count != {CNTW{1'b0}});
  assign bus.res_count = w_count;
  assign {bus.res_data, bus.res_tag, bus.res_flags} =
      bus.res_valid ? w_head : {ENTW{1'b0}};

endmodule

// File: tb/tb_i2f64_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2f64_ctrl : self-checking bench for i2f64_ctrl. Models the converter
// as an arithmetic integer-to-double rounding function with one cycle of
// latency, predicts every result from the accepted requests and compares the
// in-order output stream, stall stability, credit limits and reset flush.
// ---------------------------------------------------------------------------
module tb_i2f64_ctrl;
  import fp64Pkg::*;

  localparam int TAGW  = 6;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] d;
    logic [5:0]  t;
    logic [2:0]  f;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   stall_err = 0;
  item_t exp_q[$];
  item_t obs_q[$];
  logic  hold_prev = 1'b0;
  item_t prev;
  logic  cvt_inx;

  always #5 clk = ~clk;

  i2f64_ctrl_if #(.FPWID(FPWID), .TAGW(TAGW), .DEPTH(DEPTH)) bus ();

  i2f64_ctrl #(.TAGW(TAGW), .DEPTH(DEPTH), .CVT_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference conversion: exact value, then round the dropped bits.
  function automatic logic [63:0] ref_cvt(input logic [63:0] v, input logic op,
                                          input logic [2:0] rm, output logic inexact);
    logic        sgn;
    logic [63:0] mag, kept, rem, half;
    logic [10:0] e;
    logic        up;
    int          p, sh;
    sgn = op & v[63];
    mag = sgn ? (64'd0 - v) : v;
    inexact = 1'b0;
    if (mag == 64'd0) return 64'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e = 11'(1023 + p);
    if (p <= 52) return {sgn, e, 52'(mag << (52 - p))};
    sh   = p - 52;
    kept = mag >> sh;
    rem  = mag & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 64'd0);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = inexact && !sgn;
      3'd3:    up = inexact && sgn;
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && kept[0]);
    endcase
    if (up) kept = kept + 64'd1;
    if (kept == (64'd1 << 53)) begin
      kept = kept >> 1;
      e = e + 11'd1;
    end
    return {sgn, e, kept[51:0]};
  endfunction

  // Converter model: one ce-enabled cycle of latency.
  always @(posedge clk) begin
    if (bus.cvt_ce) bus.cvt_o <= ref_cvt(bus.cvt_i, bus.cvt_op, bus.cvt_rm, cvt_inx);
  end

  // Monitor: predicted results at accept, observed results at pop, stall hold.
  always @(negedge clk) begin : mon
    item_t it;
    item_t cur;
    logic  inx;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        it.d = ref_cvt(bus.req_int, bus.req_op, bus.req_rm, inx);
        it.t = bus.req_tag;
        it.f = {inx, bus.req_int == 64'd0, bus.req_op & bus.req_int[63]};
        exp_q.push_back(it);
      end
      cur = '{d: bus.res_data, t: bus.res_tag, f: bus.res_flags};
      if (hold_prev && (!bus.res_valid || cur !== prev)) stall_err++;
      if (bus.res_valid && bus.res_ready) obs_q.push_back(cur);
      hold_prev = bus.res_valid && !bus.res_ready;
      prev = cur;
    end
  end

  task automatic set_req(input logic [5:0] tag);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'($urandom_range(0, 100));
      1: v = {$urandom, $urandom};
      2: v = ((64'd1 << 53) | 64'($urandom_range(0, 3))) << $urandom_range(0, 10);
      3: v = 64'hFFFF_FFFF_FFFF_FFFF;
      4: v = 64'h8000_0000_0000_0000;
      default: v = {$urandom, $urandom} >> $urandom_range(0, 63);
    endcase
    bus.req_int = v;
    bus.req_op  = 1'($urandom_range(0, 1));
    bus.req_rm  = 3'($urandom_range(0, 7));
    bus.req_tag = tag;
  endtask

  // Holds a request until accepted; called and returns at posedge+1.
  task automatic send(input logic [63:0] v, input logic op, input logic [2:0] rm,
                      input logic [5:0] tag);
    int n = 0;
    bus.req_int = v; bus.req_op = op; bus.req_rm = rm; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 200);
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL send_timeout: tag %0d got req_ready=0 after %0d cycles, expected 1", tag, n);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cvt_ce !== 1'b0) begin
      errors++; $display("FAIL reset_ce: got %b expected 0", bus.cvt_ce);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_int = {$urandom, $urandom}; bus.req_op = 1'b1; bus.req_rm = 3'd3;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_count, bus.res_data, bus.res_tag, bus.res_flags} !== '0) begin
      errors++;
      $display("FAIL reset_res: got valid=%b count=%0d data=%h tag=%0d flags=%b expected all 0",
               bus.res_valid, bus.res_count, bus.res_data, bus.res_tag, bus.res_flags);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.cvt_ce !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got ready=%b ce=%b expected 1 1", bus.req_ready, bus.cvt_ce);
    end
    checks++;
    if (bus.cvt_i !== bus.req_int || bus.cvt_op !== 1'b1 || bus.cvt_rm !== 3'd3) begin
      errors++; $display("FAIL operand_copy: got i=%h op=%b rm=%0d expected i=%h op=1 rm=3",
                         bus.cvt_i, bus.cvt_op, bus.cvt_rm, bus.req_int);
    end
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] B_INT [8] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
    64'h0020_0000_0000_0001, 64'h0020_0000_0000_0001, 64'h8000_0000_0000_0000,
    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic        B_OP  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [2:0]  B_RM  [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
  localparam logic [63:0] B_EXP [8] = '{64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000,
    64'h0, 64'h4340_0000_0000_0000, 64'h4340_0000_0000_0001, 64'hC3E0_0000_0000_0000,
    64'h43E0_0000_0000_0000, 64'h43F0_0000_0000_0000};
  localparam logic [2:0]  B_FLG [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b100,
    3'b001, 3'b000, 3'b100};

  task automatic test_basic();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(B_INT[i], B_OP[i], B_RM[i], 6'(i + 5));
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0) begin
        errors++; $display("FAIL basic_early[%0d]: got res_valid=%b one cycle after accept, expected 0", i, bus.res_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== B_EXP[i]) begin
        errors++; $display("FAIL basic_data[%0d]: got valid=%b data=%h expected valid=1 data=%h",
                           i, bus.res_valid, bus.res_data, B_EXP[i]);
      end
      checks++;
      if (bus.res_tag !== 6'(i + 5) || bus.res_flags !== B_FLG[i]) begin
        errors++; $display("FAIL basic_tagflags[%0d]: got tag=%0d flags=%b expected tag=%0d flags=%b",
                           i, bus.res_tag, bus.res_flags, i + 5, B_FLG[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    int   acc = 0;
    logic took;
    exp_q.delete(); obs_q.delete();
    bus.res_ready = 1'b0;
    set_req(6'd0);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); took = bus.req_ready;
      @(posedge clk); #1;
      if (took) begin acc++; set_req(6'(acc)); end
    end
    checks++;
    if (acc != DEPTH) begin
      errors++; $display("FAIL fill_accepts: got %0d accepts expected %0d", acc, DEPTH);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.res_count !== 3'd4) begin
      errors++; $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=4",
                         bus.req_ready, bus.res_count);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      @(negedge clk); took = bus.req_ready;
      @(posedge clk); #1;
      if (took) begin acc++; set_req(6'(acc)); end
    end
    bus.req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL fill_drain_count: got %0d results expected 6", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      checks++;
      if (obs_q[i].t !== 6'(i) || i >= exp_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL fill_order[%0d]: got tag=%0d data=%h expected tag=%0d", i, obs_q[i].t, obs_q[i].d, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   acc = 0;
    logic took;
    exp_q.delete(); obs_q.delete();
    stall_err = 0;
    bus.res_ready = 1'b0;
    set_req(6'd0);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 400 && acc < 40; c++) begin
      @(negedge clk); took = bus.req_ready && bus.req_valid;
      @(posedge clk); #1;
      bus.res_ready = ~bus.res_ready;
      if (took) begin acc++; set_req(6'(acc)); end
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); took = bus.req_ready && bus.req_valid;
      @(posedge clk); #1;
      bus.res_ready = 1'($urandom_range(0, 1));
      if (took) begin acc++; set_req(6'(acc)); end
      bus.req_valid = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != acc || exp_q.size() != acc) begin
      errors++; $display("FAIL b2b_count: got %0d results (%0d predicted) expected %0d",
                         obs_q.size(), exp_q.size(), acc);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_item[%0d]: got %h/%0d/%b expected %h/%0d/%b", i,
                           obs_q[i].d, obs_q[i].t, obs_q[i].f, exp_q[i].d, exp_q[i].t, exp_q[i].f);
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++; $display("FAIL b2b_stall: got %0d unstable stall cycles expected 0", stall_err);
    end
  endtask

  task automatic test_reset_mid();
    obs_q.delete();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 1'b0, 3'd0, 6'(40 + i));
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.res_count !== 3'd3) begin
      errors++; $display("FAIL rmid_setup: got count=%0d expected 3", bus.res_count);
    end
    @(posedge clk); #1;
    send(64'd77, 1'b0, 3'd0, 6'd43);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_count !== 3'd0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_flush: got valid=%b count=%0d ready=%b expected 0 0 1",
                         bus.res_valid, bus.res_count, bus.req_ready);
    end
    @(posedge clk); #1;
    obs_q.delete();
    bus.res_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(64'd9, 1'b0, 3'd0, 6'd50);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 1 || obs_q[0].t !== 6'd50 || obs_q[0].d !== 64'h4022_0000_0000_0000) begin
      errors++; $display("FAIL rmid_stale: got %0d results first tag=%0d expected 1 result tag=50 data=4022000000000000",
                         obs_q.size(), obs_q.size() > 0 ? obs_q[0].t : 6'd0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_rm = 3'd0;
    bus.req_int = 64'd0; bus.req_tag = 6'd0; bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
